axi_inf_write_state_core: RTL and testbench
===========================================

Name: axi_inf_write_state_core

Overview:
- AXI4 write-master engine directly downstream of the stream FIFO and the FIFO-status/address generators in the video-to-memory write path.
- Accepts a single-burst request (address, beat count) and issues the AW phase.
- Drains the first-word-fall-through stream FIFO onto the W channel, collects the B response, then signals done.
- One outstanding burst at a time.

Parameters:
- IDSIZE, 3, width of axi_awid/axi_bid.
- ID, 0, constant AWID driven on every burst and expected on BID.
- LSIZE, 9, width of req_len and axi_awlen.
- ASIZE, 32, address width.
- DSIZE, 256, W data width; must be a power of two, 8..1024.

Ports:
- Clock/reset: one clock, axi_aclk; reset axi_resetn is asynchronous and active-low.
- axi_aclk  in  1  clock for all logic.
- axi_resetn  in  1  asynchronous active-low reset.
- write_req  in  1  burst request; level, sampled only in IDLE.
- req_len  in  LSIZE  beats in burst (1..2^LSIZE-1).
- req_addr  in  ASIZE  burst start byte address.
- req_resp  out  1  request accepted (1-cycle).
- req_done  out  1  burst B response received (1-cycle).
- resp_err  out  1  BRESP!=OKAY or BID!=ID on completion (1-cycle, coincident with req_done).
- fifo_empty  in  1  stream FIFO empty flag.
- pull_data_en  out  1  FIFO read enable (one word per W handshake).
- axi_awid  out  IDSIZE  constant ID.
- axi_awaddr  out  ASIZE  latched req_addr.
- axi_awlen  out  LSIZE  latched req_len-1.
- axi_awsize  out  3  log2(DSIZE/8).
- axi_awburst  out  2  2'b01 INCR.
- axi_awlock  out  1  0.
- axi_awcache  out  4  4'b0011.
- axi_awprot  out  3  0.
- axi_awqos  out  4  0.
- axi_awvalid  out  1  address valid.
- axi_awready  in  1  address ready.
- axi_wlast  out  1  last beat.
- axi_wvalid  out  1  data valid.
- axi_wready  in  1  data ready.
- axi_bready  out  1  response ready.
- axi_bid  in  IDSIZE  response ID.
- axi_bresp  in  2  response code.
- axi_bvalid  in  1  response valid.

Behaviour:
- States: IDLE, ADDR, DATA, RESP.
- Reset (async, any time incl. mid-burst): state=IDLE; beat counter=0; latched addr/len=0; awvalid, bready, req_done, resp_err=0. Combinational outputs evaluate to 0 in IDLE. No partial-burst completion; upstream FIFO is reset by the same domain.
- IDLE: req_resp = write_req (combinational). When write_req=1 and req_len!=0: latch addr/len, clear beat counter, go to ADDR.
- req_len==0: req_resp pulses; next cycle req_done=1, resp_err=0; stay IDLE; no AXI traffic.
- ADDR: axi_awvalid=1, registered, asserted the cycle after acceptance. AW fields stable until awready. On awvalid&awready go to DATA.
- DATA: axi_wvalid = !fifo_empty (combinational); wdata comes from FIFO dout outside this block.
- pull_data_en = axi_wvalid & axi_wready.
- Beat counter increments on each handshake.
- axi_wlast = (beat_cnt == len-1) while in DATA.
- Handshake with wlast: go to RESP.
- fifo_empty mid-burst: wvalid drops, counter holds, burst resumes when data returns.
- RESP: axi_bready=1, registered. On bvalid: next cycle req_done=1, resp_err=(bresp!=2'b00 || bid!=ID), state IDLE.
- A new request is accepted at the earliest in the cycle req_done is high, since state is IDLE then.
- Minimum latency for a 1-beat burst with all ready and data present: accept at T0, awvalid T1, wvalid T2, bready T3, req_done T4 (B returned T3).
- No W beats before the AW handshake completes.
- wvalid never depends on wready.
- Counter width LSIZE; no wrap, since len-1 < 2^LSIZE.

Decomposition:
- Package axi_wr_pkg: state enum (IDLE/ADDR/DATA/RESP), BURST_INCR=2'b01, RESP_OKAY=2'b00, CACHE_DEFAULT=4'b0011, function clog2 for awsize.
- Single module; beat counter and FSM inline. No sub-module is warranted.

Test Plan:
- req_addr=0x1000, req_len=4, all ready, FIFO full: awaddr=0x1000, awlen=3, awsize=5; 4 W beats on consecutive cycles, wlast on beat 4; pull_data_en high exactly 4 cycles; req_done 1 cycle after bvalid, resp_err=0.
- req_len=8, wready low on beats 2 and 5, fifo_empty high 3 cycles mid-burst: exactly 8 pull_data_en pulses; wlast only on 8th handshake; awvalid held until awready delayed 5 cycles.
- bresp=2'b10, then a separate run with bid=1 while ID=0: req_done=1 and resp_err=1 in the same cycle; next request accepted normally.
- req_len=0: req_resp, then req_done next cycle; no awvalid/wvalid activity.
- axi_resetn low during DATA after 3 of 16 beats: all outputs 0 asynchronously; after release, new req_len=2 completes with 2 beats and correct wlast.
- Back-to-back: write_req held high across two bursts (len 256, then len 1): second req_resp in the req_done cycle; awlen=255 then 0.

Source files
------------

// File: rtl/axi_inf_write_state_core_pkg.sv
// Shared types and constants for the AXI4 single-burst write engine.
// The package name is what the engine and its users import.
package axi_wr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_INCR    = 2'b01;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

  // Ceiling log2; used to derive AWSIZE from the data-bus byte width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_inf_write_state_core_if.sv
// AXI4 write-channel bundle (AW, W control, B) between the write engine and the interconnect.
// W data is supplied straight from the stream FIFO and is therefore not carried here.
interface axi_inf_write_state_core_if #(
  parameter int IDSIZE = 3,
  parameter int LSIZE  = 9,
  parameter int ASIZE  = 32
) ();

  logic [IDSIZE-1:0] axi_awid;
  logic [ASIZE-1:0]  axi_awaddr;
  logic [LSIZE-1:0]  axi_awlen;
  logic [2:0]        axi_awsize;
  logic [1:0]        axi_awburst;
  logic              axi_awlock;
  logic [3:0]        axi_awcache;
  logic [2:0]        axi_awprot;
  logic [3:0]        axi_awqos;
  logic              axi_awvalid;
  logic              axi_awready;

  logic              axi_wlast;
  logic              axi_wvalid;
  logic              axi_wready;

  logic              axi_bready;
  logic [IDSIZE-1:0] axi_bid;
  logic [1:0]        axi_bresp;
  logic              axi_bvalid;

  modport master (
    output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    input  axi_awready,
    output axi_wlast, axi_wvalid,
    input  axi_wready,
    output axi_bready,
    input  axi_bid, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awlock,
           axi_awcache, axi_awprot, axi_awqos, axi_awvalid,
    output axi_awready,
    input  axi_wlast, axi_wvalid,
    output axi_wready,
    input  axi_bready,
    output axi_bid, axi_bresp, axi_bvalid
  );

endinterface

// File: rtl/axi_inf_write_state_core.sv
// AXI4 write master: issues one INCR burst per request, drains the FWFT stream FIFO onto W,
// then reports completion and response status.
//
// state | meaning
// IDLE  | waiting for write_req; zero-length requests complete here without AXI traffic
// ADDR  | awvalid asserted, holding AW fields until awready
// DATA  | streaming FIFO words on W, wvalid follows !fifo_empty
// RESP  | bready asserted, waiting for the B response
module axi_inf_write_state_core
  import axi_wr_pkg::*;
#(
  parameter int IDSIZE = 3,
  parameter int ID     = 0,
  parameter int LSIZE  = 9,
  parameter int ASIZE  = 32,
  parameter int DSIZE  = 256
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             write_req,
  input  logic [LSIZE-1:0] req_len,
  input  logic [ASIZE-1:0] req_addr,
  output logic             req_resp,
  output logic             req_done,
  output logic             resp_err,
  input  logic             fifo_empty,
  output logic             pull_data_en,
  axi_inf_write_state_core_if.master axi
);

  localparam logic [IDSIZE-1:0] ID_V   = IDSIZE'(ID);
  localparam logic [2:0]        AWSIZE = 3'(clog2(DSIZE / 8));

  wr_state_e        state;
  logic [LSIZE-1:0] beat_cnt;
  logic [LSIZE-1:0] awlen_q;
  logic [ASIZE-1:0] addr_q;
  logic             awvalid_q;
  logic             bready_q;
  logic             req_done_q;
  logic             resp_err_q;

  logic             wvalid;
  logic             w_hs;
  logic             last_beat;

  assign wvalid    = (state == DATA) && !fifo_empty;
  assign w_hs      = wvalid && axi.axi_wready;
  assign last_beat = (beat_cnt == awlen_q);

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      awlen_q    <= '0;
      addr_q     <= '0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      req_done_q <= 1'b0;
      resp_err_q <= 1'b0;
    end else begin
      req_done_q <= 1'b0;
      resp_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (write_req) begin
            if (req_len != '0) begin
              addr_q    <= req_addr;
              awlen_q   <= req_len - LSIZE'(1);
              beat_cnt  <= '0;
              awvalid_q <= 1'b1;
              state     <= ADDR;
            end else begin
              // Zero-length request: acknowledge completion without touching the bus.
              req_done_q <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (axi.axi_awready) begin
            awvalid_q <= 1'b0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + LSIZE'(1);
            if (last_beat) begin
              bready_q <= 1'b1;
              state    <= RESP;
            end
          end
        end
        RESP: begin
          if (axi.axi_bvalid) begin
            bready_q   <= 1'b0;
            req_done_q <= 1'b1;
            resp_err_q <= (axi.axi_bresp != RESP_OKAY) || (axi.axi_bid != ID_V);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_resp     = (state == IDLE) && write_req;
  assign req_done     = req_done_q;
  assign resp_err     = resp_err_q;
  assign pull_data_en = w_hs;

  assign axi.axi_awid    = ID_V;
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awlen   = awlen_q;
  assign axi.axi_awsize  = AWSIZE;
  assign axi.axi_awburst = BURST_INCR;
  assign axi.axi_awlock  = 1'b0;
  assign axi.axi_awcache = CACHE_DEFAULT;
  assign axi.axi_awprot  = 3'b000;
  assign axi.axi_awqos   = 4'b0000;
  assign axi.axi_awvalid = awvalid_q;

  assign axi.axi_wvalid  = wvalid;
  assign axi.axi_wlast   = (state == DATA) && last_beat;

  assign axi.axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_inf_write_state_core.sv
// Scoreboard bench for the AXI write engine: stimulus pushes expected AW/W/done records,
// a negedge monitor pops and compares them as the DUT presents each event.
module tb_axi_inf_write_state_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write_req = 1'b0;
  logic [8:0]  req_len = '0;
  logic [31:0] req_addr = '0;
  logic        req_resp, req_done, resp_err, pull_data_en;
  logic        fifo_empty = 1'b0;

  always #5 clk = ~clk;

  axi_inf_write_state_core_if #(.IDSIZE(3), .LSIZE(9), .ASIZE(32)) axi_if ();

  axi_inf_write_state_core #(
    .IDSIZE(3), .ID(0), .LSIZE(9), .ASIZE(32), .DSIZE(256)
  ) dut (
    .axi_aclk     (clk),
    .axi_resetn   (rst_n),
    .write_req    (write_req),
    .req_len      (req_len),
    .req_addr     (req_addr),
    .req_resp     (req_resp),
    .req_done     (req_done),
    .resp_err     (resp_err),
    .fifo_empty   (fifo_empty),
    .pull_data_en (pull_data_en),
    .axi          (axi_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [8:0]  awlen;
  } aw_t;

  typedef struct {
    int err;
    int beats;
    int aw_cyc;
    int next_resp;
    int lat;
    int span;
  } done_t;

  aw_t   aw_q[$];
  bit    w_q[$];
  done_t done_q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave/FIFO behaviour knobs
  int       aw_delay = 0;
  int       stall_a = 0, stall_b = 0;
  int       empty_after = 0, empty_len = 0;
  logic [2:0] cfg_bid = '0;
  logic [1:0] cfg_bresp = '0;

  int  sl_beats = 0, aw_wait = 0, empty_left = 0;
  bit  stalled_a = 0, stalled_b = 0, empty_started = 0;
  bit  s_aw_hs, s_w_hs, s_wlast_hs, s_b_hs;

  initial begin
    axi_if.axi_awready = 1'b0;
    axi_if.axi_wready  = 1'b1;
    axi_if.axi_bvalid  = 1'b0;
    axi_if.axi_bid     = '0;
    axi_if.axi_bresp   = '0;
    forever begin
      @(negedge clk);
      s_aw_hs    = axi_if.axi_awvalid && axi_if.axi_awready;
      s_w_hs     = axi_if.axi_wvalid && axi_if.axi_wready;
      s_wlast_hs = s_w_hs && axi_if.axi_wlast;
      s_b_hs     = axi_if.axi_bvalid && axi_if.axi_bready;
      @(posedge clk);
      #1;
      if (s_aw_hs) begin
        sl_beats = 0; stalled_a = 0; stalled_b = 0; empty_started = 0; empty_left = 0;
      end
      if (s_w_hs) sl_beats++;
      if (empty_after != 0 && sl_beats == empty_after && !empty_started) begin
        empty_started = 1;
        empty_left    = empty_len;
      end
      if (empty_left > 0) begin
        fifo_empty = 1'b1;
        empty_left--;
      end else begin
        fifo_empty = 1'b0;
      end
      axi_if.axi_wready = 1'b1;
      if (!fifo_empty && stall_a != 0 && sl_beats == stall_a - 1 && !stalled_a) begin
        axi_if.axi_wready = 1'b0;
        stalled_a = 1;
      end
      if (!fifo_empty && stall_b != 0 && sl_beats == stall_b - 1 && !stalled_b) begin
        axi_if.axi_wready = 1'b0;
        stalled_b = 1;
      end
      if (axi_if.axi_awvalid) begin
        axi_if.axi_awready = (aw_wait >= aw_delay);
        aw_wait++;
      end else begin
        axi_if.axi_awready = 1'b0;
        aw_wait = 0;
      end
      if (s_b_hs) axi_if.axi_bvalid = 1'b0;
      if (s_wlast_hs) begin
        axi_if.axi_bvalid = 1'b1;
        axi_if.axi_bid    = cfg_bid;
        axi_if.axi_bresp  = cfg_bresp;
      end
    end
  end

  // Monitor state
  int cyc = 0;
  int m_aw_cyc = 0, m_pulls = 0, m_hs = 0, m_first = -1, m_last = -1, m_acc = 0;
  bit m_aw_done = 0;

  task automatic mon_clear();
    m_aw_cyc = 0; m_pulls = 0; m_hs = 0; m_first = -1; m_last = -1; m_aw_done = 0;
  endtask

  initial begin
    aw_t   a;
    done_t d;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (axi_if.axi_awvalid) begin
          m_aw_cyc++;
          if (axi_if.axi_awready) begin
            if (aw_q.size() == 0) chk("aw_pending", aw_q.size(), 1);
            else begin
              a = aw_q.pop_front();
              chk("awaddr", axi_if.axi_awaddr, a.addr);
              chk("awlen", axi_if.axi_awlen, a.awlen);
            end
            chk("awsize", axi_if.axi_awsize, 3'd5);
            chk("awid", axi_if.axi_awid, 3'd0);
            chk("awburst", axi_if.axi_awburst, 2'b01);
            chk("awcache", axi_if.axi_awcache, 4'b0011);
            chk("aw_lock_prot_qos", {axi_if.axi_awlock, axi_if.axi_awprot, axi_if.axi_awqos}, 8'd0);
            m_aw_done = 1;
          end
        end
        if (axi_if.axi_wvalid) chk("w_after_aw", m_aw_done, 1);
        if (pull_data_en) m_pulls++;
        if (axi_if.axi_wvalid && axi_if.axi_wready) begin
          if (w_q.size() == 0) chk("w_pending", w_q.size(), 1);
          else chk("wlast", axi_if.axi_wlast, w_q.pop_front());
          if (m_first < 0) m_first = cyc;
          m_last = cyc;
          m_hs++;
        end
        if (resp_err) chk("resp_err_with_done", req_done, 1);
        if (req_done) begin
          if (done_q.size() == 0) chk("done_pending", done_q.size(), 1);
          else begin
            d = done_q.pop_front();
            chk("resp_err", resp_err, d.err);
            chk("pull_count", m_pulls, d.beats);
            chk("awvalid_cycles", m_aw_cyc, d.aw_cyc);
            chk("req_resp_at_done", req_resp, d.next_resp);
            if (d.lat >= 0) chk("latency", cyc - m_acc, d.lat);
            if (d.span >= 0) chk("w_span", m_last - m_first, d.span);
          end
          mon_clear();
        end
        if (req_resp) m_acc = cyc;
      end
    end
  end

  task automatic push_exp(input logic [31:0] addr, input int len, input int aw_cyc,
                          input int lat, input int span, input int err, input int next_resp);
    aw_t   a;
    done_t d;
    if (len > 0) begin
      a.addr  = addr;
      a.awlen = 9'(len - 1);
      aw_q.push_back(a);
      for (int i = 0; i < len; i++) w_q.push_back(i == len - 1);
    end
    d.err = err; d.beats = len; d.aw_cyc = aw_cyc; d.next_resp = next_resp;
    d.lat = lat; d.span = span;
    done_q.push_back(d);
  endtask

  task automatic wait_resp(input int bound);
    bit got;
    got = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (req_resp) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("req_resp_seen", got, 1);
  endtask

  task automatic issue(input logic [31:0] addr, input int len);
    req_addr  = addr;
    req_len   = 9'(len);
    write_req = 1'b1;
    wait_resp(50);
    @(posedge clk);
    #1;
    write_req = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done_q.size() != 0; i++) @(posedge clk);
    chk("done_drained", done_q.size(), 0);
    chk("w_drained", w_q.size(), 0);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_awvalid"}, axi_if.axi_awvalid, 0);
    chk({tag, "_wvalid"}, axi_if.axi_wvalid, 0);
    chk({tag, "_wlast"}, axi_if.axi_wlast, 0);
    chk({tag, "_bready"}, axi_if.axi_bready, 0);
    chk({tag, "_pull"}, pull_data_en, 0);
    chk({tag, "_req_done"}, req_done, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_req_resp"}, req_resp, 0);
    chk({tag, "_awaddr"}, axi_if.axi_awaddr, 0);
    chk({tag, "_awlen"}, axi_if.axi_awlen, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_idle_outputs("reset");
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4-beat burst, everything ready: latency len+3, consecutive beats
    push_exp(32'h1000, 4, 1, 7, 3, 0, 0);
    issue(32'h1000, 4);
    wait_done(100);

    // 8 beats with AW delay, two wready stalls and a 3-cycle FIFO underrun
    aw_delay = 5; stall_a = 2; stall_b = 5; empty_after = 3; empty_len = 3;
    push_exp(32'h0002_0040, 8, 6, 21, 12, 0, 0);
    issue(32'h0002_0040, 8);
    wait_done(200);
    aw_delay = 0; stall_a = 0; stall_b = 0; empty_after = 0; empty_len = 0;

    // SLVERR response, then BID mismatch, then a clean burst
    cfg_bresp = 2'b10;
    push_exp(32'h0000_3000, 2, 1, 5, 1, 1, 0);
    issue(32'h0000_3000, 2);
    wait_done(100);
    cfg_bresp = 2'b00; cfg_bid = 3'd1;
    push_exp(32'h0000_4000, 3, 1, 6, 2, 1, 0);
    issue(32'h0000_4000, 3);
    wait_done(100);
    cfg_bid = 3'd0;
    push_exp(32'h0000_5000, 1, 1, 4, 0, 0, 0);
    issue(32'h0000_5000, 1);
    wait_done(100);

    // Zero-length request: done the next cycle, no bus activity
    push_exp(32'h0000_6000, 0, 0, 1, -1, 0, 0);
    issue(32'h0000_6000, 0);
    wait_done(20);

    // Reset in the middle of a 16-beat burst after 3 beats
    push_exp(32'h0000_7000, 16, 1, -1, -1, 0, 0);
    issue(32'h0000_7000, 16);
    for (int i = 0; i < 100 && m_hs < 3; i++) @(posedge clk);
    chk("beats_before_reset", m_hs, 3);
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    aw_q.delete();
    w_q.delete();
    done_q.delete();
    mon_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_exp(32'h0000_8000, 2, 1, 5, 1, 0, 0);
    issue(32'h0000_8000, 2);
    wait_done(100);

    // Back-to-back with write_req held: 256 beats then 1 beat
    push_exp(32'h0010_0000, 256, 1, 259, 255, 0, 1);
    push_exp(32'h0020_0000, 1, 1, 4, 0, 0, 0);
    req_addr  = 32'h0010_0000;
    req_len   = 9'd256;
    write_req = 1'b1;
    wait_resp(50);
    @(posedge clk);
    #1;
    req_addr = 32'h0020_0000;
    req_len  = 9'd1;
    wait_resp(400);
    @(posedge clk);
    #1;
    write_req = 1'b0;
    wait_done(100);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
